// File: rtl/mux_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : mux_input_conditioner
// Description : Synchronises and debounces two 4-bit switch banks and a select
//               input feeding a downstream 2:1 mux; flags output changes.
//               Optional macro SEL_TOGGLE_EN makes the select a toggle button.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A_SW,
    input  logic [3:0] B_SW,
    input  logic       SEL_BTN,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       S,
    output logic       CHG
);

    localparam int               c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    // Packed raw bus: [3:0] bank A, [7:4] bank B, [8] select input
    logic [8:0] w_raw;
    logic [8:0] r_sync1;
    logic [8:0] r_sync2;
    logic [8:0] w_stable;
    logic       w_sel;
    logic [8:0] w_outs;
    logic [8:0] r_outs_prev;
    logic       r_chg;

    assign w_raw = {SEL_BTN, B_SW, A_SW};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // One debouncer per group; each group qualifies its whole vector at once
    for (genvar g = 0; g < 3; g++) begin : g_grp
        localparam int c_lo = (g == 2) ? 8 : g * 4;
        localparam int c_w  = (g == 2) ? 1 : 4;

        logic [c_w-1:0]     w_smp;
        logic [c_w-1:0]     r_cand;
        logic [c_w-1:0]     r_stable;
        logic [c_cnt_w-1:0] r_cnt;

        assign w_smp = r_sync2[c_lo +: c_w];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cand   <= '0;
                r_stable <= '0;
                r_cnt    <= '0;
            end else if (w_smp != r_cand) begin
                r_cand <= w_smp;
                r_cnt  <= '0;
            end else if (r_cnt < c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end else begin
                r_stable <= r_cand;
            end
        end

        assign w_stable[c_lo +: c_w] = r_stable;
    end

`ifdef SEL_TOGGLE_EN
    logic r_btn_prev;
    logic r_sel;

    // Momentary button: flip the select on each accepted press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_prev <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_btn_prev <= w_stable[8];
            if (w_stable[8] && !r_btn_prev) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign w_sel = r_sel;
`else
    assign w_sel = w_stable[8];
`endif

    assign w_outs = {w_sel, w_stable[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outs_prev <= '0;
            r_chg       <= 1'b0;
        end else begin
            r_outs_prev <= w_outs;
            r_chg       <= (w_outs != r_outs_prev);
        end
    end

    assign A   = w_stable[3:0];
    assign B   = w_stable[7:4];
    assign S   = w_sel;
    assign CHG = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_mux_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_input_conditioner
// Description : Randomised and directed scoreboard bench for the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] A_SW = 4'b0000;
    logic [3:0] B_SW = 4'b0000;
    logic       SEL_BTN = 1'b0;
    logic [3:0] A;
    logic [3:0] B;
    logic       S;
    logic       CHG;

    mux_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .A_SW    (A_SW),
        .B_SW    (B_SW),
        .SEL_BTN (SEL_BTN),
        .A       (A),
        .B       (B),
        .S       (S),
        .CHG     (CHG)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: a value is accepted once it has been the synchronised
    // sample for D+1 consecutive edges (reset counts as one sample of zero).
    logic [8:0] m_d1 = '0, m_d2 = '0, m_smp, m_old_outs, m_prev_outs = '0;
    logic [3:0] m_last[3] = '{default: '0};
    logic [3:0] m_stab[3] = '{default: '0};
    int         m_run[3]  = '{default: 1};
    logic       m_s = 1'b0, m_chg = 1'b0, m_btn_prev = 1'b0, m_old_btn;
    logic [3:0] m_v;

    function automatic logic [3:0] grp(input logic [8:0] v, input int g);
        case (g)
            0:       return v[3:0];
            1:       return v[7:4];
            default: return {3'b000, v[8]};
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_prev_outs = '0;
            m_s = 1'b0; m_chg = 1'b0; m_btn_prev = 1'b0;
            for (int g = 0; g < 3; g++) begin
                m_last[g] = '0; m_stab[g] = '0; m_run[g] = 1;
            end
        end else begin
            m_smp = m_d2;
            m_d2  = m_d1;
            m_d1  = {SEL_BTN, B_SW, A_SW};
            m_old_outs = {m_s, m_stab[1], m_stab[0]};
            m_old_btn  = m_stab[2][0];
            for (int g = 0; g < 3; g++) begin
                m_v = grp(m_smp, g);
                if (m_v == m_last[g]) m_run[g]++;
                else begin
                    m_last[g] = m_v;
                    m_run[g]  = 1;
                end
                if (m_run[g] >= D + 1) m_stab[g] = m_v;
            end
`ifdef SEL_TOGGLE_EN
            if (m_old_btn && !m_btn_prev) m_s = ~m_s;
            m_btn_prev = m_old_btn;
`else
            m_s = m_stab[2][0];
`endif
            m_chg       = (m_old_outs != m_prev_outs);
            m_prev_outs = m_old_outs;
            exp_q.push_back('{a: m_stab[0], b: m_stab[1], s: m_s, chg: m_chg});
        end
    end

    // Monitor: the DUT presents a result every cycle outside reset
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            checks++;
            if ({A, B, S, CHG} !== 10'b0) begin
                errors++;
                $display("FAIL reset_state cyc %0d: got A=%b B=%b S=%b CHG=%b, expected all zero",
                         cyc, A, B, S, CHG);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (A !== e.a || B !== e.b || S !== e.s || CHG !== e.chg) begin
                errors++;
                $display("FAIL outputs cyc %0d: got A=%b B=%b S=%b CHG=%b, expected A=%b B=%b S=%b CHG=%b",
                         cyc, A, B, S, CHG, e.a, e.b, e.s, e.chg);
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        hold(3);
        rst = 1'b0;

        // Clean steps on both banks from reset
        A_SW = 4'b1001; B_SW = 4'b0110;
        hold(12);
        A_SW = 4'b0000;
        hold(10);

        // Short glitch that must be rejected
        A_SW = 4'b1111; hold(3);
        A_SW = 4'b0000; hold(10);

        // Sustained bounce on bank B, then settle high
        for (int i = 0; i < 10; i++) begin
            B_SW = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            hold(2);
        end
        B_SW = 4'b1111;
        hold(12);

        // Two clean presses of the select input
        repeat (2) begin
            SEL_BTN = 1'b1; hold(10);
            SEL_BTN = 1'b0; hold(10);
        end

        // Reset in the middle of a qualification
        A_SW = 4'b0101; hold(5);
        rst = 1'b1; hold(2);
        rst = 1'b0; hold(12);

        // Randomised mixture of bounces and settled changes
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) A_SW = 4'($urandom);
            if ($urandom_range(0, 2) == 0) B_SW = 4'($urandom);
            if ($urandom_range(0, 3) == 0) SEL_BTN = ~SEL_BTN;
            if (i == 60) begin
                rst = 1'b1; hold(1); rst = 1'b0;
            end
            hold($urandom_range(1, 9));
        end
        hold(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_input_conditioner.md
MUX_INPUT_CONDITIONER -- requirements
Module: mux_input_conditioner

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required to accept a new input value; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port A_SW, input, 4, raw asynchronous switch bank A.
REQ-005 SHALL have port B_SW, input, 4, raw asynchronous switch bank B.
REQ-006 SHALL have port SEL_BTN, input, 1, raw asynchronous select button or switch.
REQ-007 SHALL have port A, output, 4, debounced bank A; feeds downstream 2:1 mux data input A.
REQ-008 SHALL have port B, output, 4, debounced bank B; feeds downstream mux data input B.
REQ-009 SHALL have port S, output, 1, select; feeds downstream mux select (0 selects A, 1 selects B).
REQ-010 SHALL have port CHG, output, 1, single-cycle pulse flagging any change on A, B or S.

Function
REQ-011 SHALL pass each of the 9 raw inputs through a two-flop synchronizer before any other use.
REQ-012 SHALL debounce three independent groups: A bank (4-bit vector), B bank (4-bit vector), button (1 bit); each group has its own candidate register, counter and stable register.
REQ-013 Per group, SHALL, when the synchronized sample differs from the candidate, load the candidate with the sample and clear the counter to 0.
REQ-014 Per group, SHALL, when the sample equals the candidate and the counter is below DEBOUNCE_CYCLES-1, increment the counter; the counter saturates at DEBOUNCE_CYCLES-1 and never wraps.
REQ-015 Per group, SHALL, when the sample equals the candidate and the counter equals DEBOUNCE_CYCLES-1, load the stable register from the candidate.
REQ-016 A and B SHALL be driven directly from their stable registers.
REQ-017 A clean step held steady SHALL appear on A or B on rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples the new raw value as edge 1.
REQ-018 Any bounce that changes the synchronized sample before acceptance SHALL restart that group's count; the stable value is unchanged.
REQ-019 A pulse that returns to the current stable value before acceptance SHALL never reach the outputs.
REQ-020 Groups SHALL be fully independent; simultaneous changes on several groups are each accepted per their own counts.
REQ-021 CHG SHALL be high for exactly one cycle, the cycle immediately after any edge on which A, B or S changed value; simultaneous changes yield one pulse.
REQ-022 CHG SHALL never be asserted for two consecutive cycles unless outputs changed on two consecutive edges.

Reset
REQ-023 While rst is high, all synchronizer flops, candidates, counters, stable registers, the edge-detect register, S and CHG SHALL be 0; A=4'b0000, B=4'b0000, S=0, CHG=0.
REQ-024 Reset asserted mid-debounce SHALL discard all in-progress counts; after release, inputs are re-qualified from count 0 against candidates of 0.
REQ-025 Inputs already high at reset release SHALL reach outputs per REQ-017 timing; that first change SHALL produce a CHG pulse.

Configuration
REQ-026 Macro SEL_TOGGLE_EN defined: SEL_BTN is a momentary button; S SHALL toggle one cycle after each 0-to-1 transition of the debounced button stable register; 1-to-0 transitions and holding SHALL not affect S.
REQ-027 SEL_TOGGLE_EN undefined: SEL_BTN is a slide switch; S SHALL equal the debounced button stable register with no extra delay.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, then A_SW=4'b1001, B_SW=4'b0110 held -> A=4'b1001 and B=4'b0110 on edge 7; one CHG pulse on edge 8; S=0.
REQ-029 A_SW goes 0000->1111 for 3 cycles then back to 0000 -> A stays 4'b0000, CHG never asserts.
REQ-030 B_SW toggles 0000/1111 every 2 cycles for 20 cycles then holds 1111 -> B=4'b1111 exactly 7 edges after final transition, no earlier change.
REQ-031 SEL_TOGGLE_EN defined, two clean button presses of 10 cycles each -> S goes 0->1 after first press, 1->0 after second, one CHG per toggle; undefined, SEL_BTN held high -> S=1 on edge 7, returns 0 7 edges after release.
REQ-032 rst pulsed high at edge 5 of an A_SW change -> A=4'b0000 immediately; after release A updates 7 edges later with one CHG pulse.
